// File: rtl/imm_decode_stage.sv
// imm_decode_stage
// Registered immediate-generation stage sitting between fetch and decode/issue.
// Each beat carries LANES instructions. Every valid lane is decoded into an
// XLEN-bit immediate plus a 3-bit format tag. The result is registered into an
// output register (OUT) that is backed by one skid register (SKID).
//
// Handshake contract, the same on both sides:
//   a beat moves across an interface on a rising clk_i edge where valid and
//   ready are both high. valid may only be withdrawn after that transfer, and
//   the payload must not change while valid is high and ready is low.
//
// ready_o is driven straight from the SKID occupancy flag. Because of that,
// ready_i never reaches ready_o through combinational logic.
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int LANES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [LANES*32-1:0]   instr_i,
  input  logic [LANES-1:0]      lane_valid_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [LANES*XLEN-1:0] imm_o,
  output logic [LANES*3-1:0]    fmt_o,
  output logic [LANES-1:0]      lane_valid_o
);

  // Major opcodes, instr[6:0]
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_IMM_32  = 7'b0011011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  // Format tags. Code 7 is reserved and is never produced.
  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  // A beat as it is stored in OUT or SKID
  typedef struct packed {
    logic [LANES-1:0][XLEN-1:0] imm;
    logic [LANES-1:0][2:0]      fmt;
    logic [LANES-1:0]           lv;
  } beat_t;

  // Select the format tag from the opcode. OP-IMM-32 only exists on RV64.
  function automatic logic [2:0] lane_fmt(input logic [31:0] ins);
    logic [2:0] f;
    f = FMT_NONE;
    case (ins[6:0])
      OPC_LUI, OPC_AUIPC:              f = FMT_U;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:  f = FMT_I;
      OPC_IMM_32:                      f = (XLEN == 64) ? FMT_I : FMT_NONE;
      OPC_STORE:                       f = FMT_S;
      OPC_BRANCH:                      f = FMT_B;
      OPC_JAL:                         f = FMT_J;
      OPC_SYSTEM:                      f = ins[14] ? FMT_Z : FMT_NONE;
      default:                         f = FMT_NONE;
    endcase
    return f;
  endfunction

  // Build the 32-bit immediate, then sign-extend it to XLEN.
  // For every format the sign sits at bit 31 of that 32-bit value. This also
  // covers U on RV64 (bit 31 is replicated up to bit 63) and Z (the upper
  // bits are zero, so extending them keeps zero).
  function automatic logic [XLEN-1:0] lane_imm(input logic [31:0] ins,
                                               input logic [2:0]  f);
    logic [31:0] raw;
    raw = '0;
    case (f)
      FMT_I: raw = {{20{ins[31]}}, ins[31:20]};
      FMT_S: raw = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B: raw = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U: raw = {ins[31:12], 12'b0};
      FMT_J: raw = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      FMT_Z: raw = {27'b0, ins[19:15]};
      default: raw = '0;
    endcase
    return XLEN'($signed(raw));
  endfunction

  beat_t dec;
  beat_t out_q;
  beat_t skid_q;
  logic  out_valid_q;
  logic  skid_valid_q;
  logic  in_fire;
  logic  out_fire;

  // Decode every lane of the incoming beat. Masked-off lanes stay at zero/NONE.
  always_comb begin
    dec    = '0;
    dec.lv = lane_valid_i;
    for (int k = 0; k < LANES; k++) begin
      if (lane_valid_i[k]) begin
        dec.fmt[k] = lane_fmt(instr_i[32*k +: 32]);
        dec.imm[k] = lane_imm(instr_i[32*k +: 32], lane_fmt(instr_i[32*k +: 32]));
      end
    end
  end

  assign ready_o  = !skid_valid_q;
  assign in_fire  = valid_i && ready_o;
  assign out_fire = out_valid_q && ready_i;

  // Track OUT/SKID occupancy. An entry that is empty always holds zeros.
  // SKID only fills while OUT is stalled, so SKID always has the younger beat.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (skid_valid_q) begin
      // Input is blocked here (ready_o=0). Only a drain of OUT is possible.
      if (out_fire) begin
        out_q        <= skid_q;
        skid_q       <= '0;
        skid_valid_q <= 1'b0;
      end
    end else if (!out_valid_q) begin
      if (in_fire) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end
    end else if (out_fire) begin
      if (in_fire) begin
        out_q <= dec;
      end else begin
        out_q       <= '0;
        out_valid_q <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
    end
  end

  assign valid_o      = out_valid_q;
  assign imm_o        = out_q.imm;
  assign fmt_o        = out_q.fmt;
  assign lane_valid_o = out_q.lv;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage. Two instances run in lockstep on the same
// stimulus: one with XLEN=32, LANES=4 and one with XLEN=64, LANES=4.
module tb_imm_decode_stage;

  localparam int EW = 412; // {lv4, fmt64 12, fmt32 12, imm32 128, imm64 256}

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_i, flush_i, valid_i, ready_i;
  logic [127:0] instr_i;
  logic [3:0]   lane_valid_i;
  logic         ready32, valid32, ready64, valid64;
  logic [127:0] imm32;
  logic [255:0] imm64;
  logic [11:0]  fmt32, fmt64;
  logic [3:0]   lv32, lv64;

  imm_decode_stage #(.XLEN(32), .LANES(4)) dut32 (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(ready32), .instr_i(instr_i), .lane_valid_i(lane_valid_i),
    .valid_o(valid32), .ready_i(ready_i), .imm_o(imm32), .fmt_o(fmt32),
    .lane_valid_o(lv32));

  imm_decode_stage #(.XLEN(64), .LANES(4)) dut64 (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(ready64), .instr_i(instr_i), .lane_valid_i(lane_valid_i),
    .valid_o(valid64), .ready_i(ready_i), .imm_o(imm64), .fmt_o(fmt64),
    .lane_valid_o(lv64));

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  bit            mon_en = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference decode of a single lane: {fmt, 64-bit immediate}
  function automatic logic [66:0] ref_lane(input logic [31:0] x, input bit is64);
    logic [63:0] v;
    logic [2:0]  f;
    v = '0;
    f = 3'd0;
    case (x[6:0])
      7'b0110111, 7'b0010111: begin f = 3'd4; v = {{32{x[31]}}, x[31:12], 12'h000}; end
      7'b0010011, 7'b0000011, 7'b1100111: begin f = 3'd1; v = {{52{x[31]}}, x[31:20]}; end
      7'b0011011: if (is64) begin f = 3'd1; v = {{52{x[31]}}, x[31:20]}; end
      7'b0100011: begin f = 3'd2; v = {{52{x[31]}}, x[31:25], x[11:7]}; end
      7'b1100011: begin f = 3'd3; v = {{51{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0}; end
      7'b1101111: begin f = 3'd5; v = {{43{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0}; end
      7'b1110011: if (x[14]) begin f = 3'd6; v = {59'd0, x[19:15]}; end
      default: ;
    endcase
    return {f, v};
  endfunction

  function automatic logic [EW-1:0] ref_beat(input logic [127:0] ins, input logic [3:0] lv);
    logic [255:0] i64;
    logic [127:0] i32;
    logic [11:0]  f64, f32;
    logic [66:0]  r;
    i64 = '0; i32 = '0; f64 = '0; f32 = '0;
    for (int k = 0; k < 4; k++) begin
      if (lv[k]) begin
        r = ref_lane(ins[32*k +: 32], 1'b1);
        i64[64*k +: 64] = r[63:0];
        f64[3*k +: 3]   = r[66:64];
        r = ref_lane(ins[32*k +: 32], 1'b0);
        i32[32*k +: 32] = r[31:0];
        f32[3*k +: 3]   = r[66:64];
      end
    end
    return {lv, f64, f32, i32, i64};
  endfunction

  // Monitor on the falling edge. It checks occupancy and the head-of-queue
  // payload, then updates the queue for the transfers of the coming edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("valid32", valid32, exp_q.size() > 0);
      check("ready32", ready32, exp_q.size() < 2);
      check("valid64", valid64, exp_q.size() > 0);
      check("ready64", ready64, exp_q.size() < 2);
      if (exp_q.size() > 0 && valid32) begin
        check("imm32", imm32, exp_q[0][383:256]);
        check("fmt32", fmt32, exp_q[0][395:384]);
        check("lv32",  lv32,  exp_q[0][411:408]);
        check("imm64", imm64, exp_q[0][255:0]);
        check("fmt64", fmt64, exp_q[0][407:396]);
        check("lv64",  lv64,  exp_q[0][411:408]);
      end
      if (rst_i || flush_i) begin
        exp_q.delete();
      end else begin
        if (valid32 && ready_i && exp_q.size() > 0) void'(exp_q.pop_front());
        if (valid_i && ready32) exp_q.push_back(ref_beat(instr_i, lane_valid_i));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present a beat, hold it until it is accepted, then release valid_i.
  task automatic send(input logic [127:0] ins, input logic [3:0] lv);
    int t;
    t = 0;
    instr_i = ins; lane_valid_i = lv; valid_i = 1'b1;
    @(negedge clk);
    while (!ready32 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("send_timeout", 1'b1, 1'b0);
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    ready_i = 1'b1;
    while (exp_q.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic lane32(input string tag, input int k, input logic [31:0] imm, input logic [2:0] f);
    check({tag, "_imm32"}, imm32[32*k +: 32], imm);
    check({tag, "_fmt32"}, fmt32[3*k +: 3], f);
  endtask

  task automatic lane64(input string tag, input int k, input logic [63:0] imm, input logic [2:0] f);
    check({tag, "_imm64"}, imm64[64*k +: 64], imm);
    check({tag, "_fmt64"}, fmt64[3*k +: 3], f);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] x;
    logic [6:0]  opc;
    x = $urandom();
    case ($urandom_range(0, 11))
      0: opc = 7'b0110111;  1: opc = 7'b0010111;  2: opc = 7'b0010011;
      3: opc = 7'b0000011;  4: opc = 7'b1100111;  5: opc = 7'b0100011;
      6: opc = 7'b1100011;  7: opc = 7'b1101111;  8: opc = 7'b1110011;
      9: opc = 7'b0011011;  10: opc = 7'b0110011; default: opc = x[6:0];
    endcase
    x[6:0] = opc;
    return x;
  endfunction

  // Stop a hung run
  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit done;
    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    instr_i = '0; lane_valid_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    // Reset state
    check("rst_valid", valid32, 1'b0);
    check("rst_ready", ready32, 1'b1);
    check("rst_imm32", imm32, '0);
    check("rst_fmt32", fmt32, '0);
    check("rst_lv32",  lv32,  '0);
    check("rst_imm64", imm64, '0);
    mon_en = 1'b1;

    // Known encodings: addi, sw, beq, lui
    ready_i = 1'b1;
    send({32'h123452B7, 32'h00000863, 32'hFE112E23, 32'hFFF00093}, 4'hF);
    lane32("addi", 0, 32'hFFFFFFFF, 3'd1);
    lane32("sw",   1, 32'hFFFFFFFC, 3'd2);
    lane32("beq",  2, 32'h00000010, 3'd3);
    lane32("lui",  3, 32'h12345000, 3'd4);
    lane64("addi", 0, 64'hFFFFFFFF_FFFFFFFF, 3'd1);
    lane64("lui",  3, 64'h00000000_12345000, 3'd4);

    // jal, csrrwi, addiw, ecall
    send({32'h00000073, 32'h0050809B, 32'h300FD0F3, 32'hFF9FF06F}, 4'hF);
    lane32("jal",   0, 32'hFFFFFFF8, 3'd5);
    lane32("csr",   1, 32'h0000001F, 3'd6);
    lane32("addiw", 2, 32'h00000000, 3'd0);
    lane32("ecall", 3, 32'h00000000, 3'd0);
    lane64("jal",   0, 64'hFFFFFFFF_FFFFFFF8, 3'd5);
    lane64("addiw", 2, 64'h5, 3'd1);

    // Lane mask 0101
    send({4{32'hFFF00093}}, 4'b0101);
    lane32("m0", 0, 32'hFFFFFFFF, 3'd1);
    lane32("m1", 1, 32'h0, 3'd0);
    lane32("m3", 3, 32'h0, 3'd0);
    check("mask_lv", lv32, 4'b0101);
    drain();

    // Backpressure: A in OUT, B in SKID, C held until ready_i returns
    ready_i = 1'b0;
    send({96'd0, 32'h00100093}, 4'b0001);
    send({96'd0, 32'h00200093}, 4'b0001);
    fork
      send({96'd0, 32'h00300093}, 4'b0001);
      begin
        repeat (3) @(posedge clk);
        #2;
        check("bp_ready", ready32, 1'b0);
        check("bp_valid", valid32, 1'b1);
        check("bp_imm_a", imm32[31:0], 32'h1);
        ready_i = 1'b1;
      end
    join
    drain();

    // Flush with both entries full and a new beat offered
    ready_i = 1'b0;
    send({96'd0, 32'h00400093}, 4'b0001);
    send({96'd0, 32'h00500093}, 4'b0001);
    instr_i = {96'd0, 32'h00600093}; lane_valid_i = 4'b0001;
    valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; valid_i = 1'b0;
    check("fl_valid", valid32, 1'b0);
    check("fl_ready", ready32, 1'b1);
    check("fl_imm",   imm32, '0);
    ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of a transfer
    ready_i = 1'b0;
    send({96'd0, 32'h00700093}, 4'b0001);
    send({96'd0, 32'h00800093}, 4'b0001);
    instr_i = {96'd0, 32'h00900093}; valid_i = 1'b1; rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0; valid_i = 1'b0;
    check("rs_valid", valid32, 1'b0);
    check("rs_ready", ready32, 1'b1);
    check("rs_lv",    lv32, '0);
    ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Random traffic with random backpressure
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 10000; n++) begin
          repeat ($urandom_range(0, 1)) begin
            @(posedge clk); #1;
          end
          send({rnd_instr(), rnd_instr(), rnd_instr(), rnd_instr()}, 4'($urandom_range(0, 15)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
